uart_tx_ctrl: RTL
=================

Name: uart_tx_ctrl

Overview:
- Transmit sequencer for the UART datapath: drains bytes from the 4-deep transmit FIFO and serialises each onto the tx line as a standard asynchronous frame.
- Sits between the transmit FIFO's read side (empty, data_out, rd_en) and the tx pin.
- Framing controls and baud divisor come from the APB register block.

Parameters:
- DATA_W, 8, data bits per frame; must match the FIFO width.
- DIV_W, 16, width of the baud divisor input.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous assert, active-low
- tx_enable  input  1  transmitter enable from the APB control register
- baud_div  input  DIV_W  clocks per bit; 0 is treated as 1
- stop2  input  1  0 = one stop bit, 1 = two stop bits
- parity_en  input  1  insert a parity bit (effective only with the optional feature)
- parity_odd  input  1  0 = even parity, 1 = odd parity
- fifo_empty  input  1  FIFO empty flag
- fifo_data  input  DATA_W  FIFO registered head data
- fifo_rd_en  output  1  pop strobe to the FIFO
- tx  output  1  serial line, idle high
- busy  output  1  high in any state other than IDLE
- tx_done  output  1  one-cycle pulse on the last stop-bit tick

Behaviour:
- Reset values: tx=1, fifo_rd_en=0, busy=0, tx_done=0, state=IDLE, all counters=0. Reset asserted mid-frame aborts the frame immediately and drives tx=1 asynchronously.
- State machine states: IDLE, LOAD, START, DATA, PARITY, STOP.
- IDLE -> LOAD when tx_enable=1 and fifo_empty=0.
- LOAD lasts exactly one cycle, which covers the FIFO's one-cycle registered-output lag.
  - fifo_rd_en=1 combinationally in LOAD only, so exactly one pop per frame.
  - On the exiting edge: shift register <= fifo_data; baud_div, stop2, parity_en and parity_odd are latched for the whole frame; tx <= 0; state -> START.
- Latency: tx falls 2 clocks after the first cycle in which fifo_empty=0 is sampled in IDLE.
- Baud tick:
  - Counter runs 0..div-1 and restarts at every state entry. Each bit lasts exactly div clocks.
  - A latched divisor of 0 is treated as 1, giving 1 clock per bit.
- START lasts 1 bit, then -> DATA.
- DATA shifts DATA_W bits, LSB first. A 3-bit index advances on each tick. After the last bit -> PARITY if parity is enabled, else -> STOP.
- PARITY lasts 1 bit. Its value is the XOR of the data bits, inverted when parity_odd=1.
- STOP lasts 1 bit (stop2=0) or 2 bits (stop2=1), with tx=1.
  - tx_done pulses in the final clock of STOP.
  - Next state -> LOAD if tx_enable=1 and fifo_empty=0 (back-to-back frames, no idle gap); else -> IDLE.
- tx_enable deasserted mid-frame: the current frame completes and no new frame starts.
- fifo_empty is sampled only in IDLE and at STOP exit. A write arriving during a frame is picked up at STOP exit.
- Config inputs changing mid-frame have no effect until the next LOAD.
- tx is registered (glitch-free).

Optional Feature:
- UART_TX_PARITY_EN defined: PARITY state and the parity_en/parity_odd logic are built.
- UART_TX_PARITY_EN undefined: the PARITY state is removed; parity_en and parity_odd remain as ports but are ignored; frames are always 8N1 or 8N2.

Decomposition:
- Package uart_pkg holds:
  - the state enum (3-bit encoding);
  - DATA_W_DEF=8 and DIV_W_DEF=16;
  - the data-bit index width constant.
- Sub-module uart_baud_gen contains the divisor counter. Inputs: clk, rst_n, restart, div. Output: tick. It is shared later with the receive path.

Test Plan:
- Reset, then push 0xA5 with baud_div=4, stop2=0, parity off -> fifo_rd_en high for exactly 1 cycle; tx sequence 0,1,0,1,0,0,1,0,1,1 with each bit held 4 clocks; tx_done pulses once at clock 40 of the frame.
- Push 0x01, 0x02, 0x03, 0x04 back-to-back (FIFO full) -> 4 frames with no idle gap; exactly 4 pops; busy stays high throughout; tx_done pulses 4 times.
- UART_TX_PARITY_EN defined, parity_en=1, parity_odd=0, data 0x07 -> parity bit=1; with parity_odd=1 -> parity bit=0; frame is 11 bits long.
- stop2=1, baud_div=0 -> every bit is 1 clock; stop phase is 2 clocks high; total frame is 11 clocks.
- Deassert tx_enable during DATA of the first of two queued bytes -> first frame completes; second byte stays in the FIFO (fifo_empty=0); state returns to IDLE with tx=1.
- Assert rst_n=0 during bit 3 of a frame -> tx=1 immediately; busy=0; on release, a byte pushed into the FIFO is transmitted normally.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART datapath.
// Contents:
//   DATA_W_DEF, DIV_W_DEF  default data width and baud divisor width
//   IDX_W                  width of the data-bit index inside a frame
//   state_e                transmit sequencer states (3-bit encoding)
// Optional feature macro: UART_TX_PARITY_EN (adds the StParity state).
package uart_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned DIV_W_DEF  = 16;
  localparam int unsigned IDX_W      = 3;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLoad   = 3'd1,
    StStart  = 3'd2,
    StData   = 3'd3,
`ifdef UART_TX_PARITY_EN
    StParity = 3'd4,
`endif
    StStop   = 3'd5
  } state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter shared by the transmit and receive paths.
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   restart  clears the counter so the next bit starts a full period from now
//   div      clocks per bit; 0 is treated as 1
//   tick     high in the last clock of each bit period
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] div_eff;

  assign div_eff = (div == '0) ? DIV_W'(1) : div;
  assign tick    = (cnt_q == div_eff - DIV_W'(1));

  // Counter runs 0..div-1; a tick wraps it so consecutive bits stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (restart || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: transmit sequencer. Pops one byte per frame from the transmit
// FIFO and serialises it LSB first as start / data / [parity] / stop bits.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   tx_enable               allow new frames to start
//   baud_div                clocks per bit (0 treated as 1), latched per frame
//   stop2                   two stop bits when set, latched per frame
//   parity_en, parity_odd   parity control, latched per frame
//   fifo_empty, fifo_data   FIFO status and registered head data
//   fifo_rd_en              pop strobe, high only in StLoad
//   tx                      registered serial line, idle high
//   busy                    high whenever the sequencer is not idle
//   tx_done                 pulse in the last clock of the final stop bit
// Optional feature macro: UART_TX_PARITY_EN. When undefined there is no parity
// state and parity_en / parity_odd are ignored.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DIV_W  = DIV_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_enable,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic              stop2,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  state_e            state_q;
  logic [DATA_W-1:0] shift_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DIV_W-1:0]  div_q;
  logic              stop2_q;
  logic              stop_cnt_q;  // set while in the second of two stop bits
  logic              tx_q;
  logic              tick;
  logic              restart;
  logic              last_stop;

`ifdef UART_TX_PARITY_EN
  logic par_en_q;
  logic par_bit_q;
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = parity_en ^ parity_odd;
`endif

  // Holding the counter in reset through StIdle/StLoad makes StStart begin a
  // full bit period; later state changes coincide with a tick, which wraps it.
  assign restart = (state_q == StIdle) || (state_q == StLoad);

  uart_baud_gen #(
    .DIV_W (DIV_W)
  ) u_baud_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .div     (div_q),
    .tick    (tick)
  );

  assign last_stop  = (state_q == StStop) && tick && (!stop2_q || stop_cnt_q);
  assign fifo_rd_en = (state_q == StLoad);
  assign busy       = (state_q != StIdle);
  assign tx_done    = last_stop;
  assign tx         = tx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      idx_q      <= '0;
      div_q      <= '0;
      stop2_q    <= 1'b0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (tx_enable && !fifo_empty) begin
            state_q <= StLoad;
          end
        end
        StLoad: begin
          // FIFO head is valid this cycle; capture it with the frame config.
          shift_q    <= fifo_data;
          div_q      <= baud_div;
          stop2_q    <= stop2;
          idx_q      <= '0;
          stop_cnt_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
          par_en_q   <= parity_en;
          par_bit_q  <= (^fifo_data) ^ parity_odd;
`endif
          tx_q       <= 1'b0;
          state_q    <= StStart;
        end
        StStart: begin
          if (tick) begin
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            state_q <= StData;
          end
        end
        StData: begin
          if (tick) begin
            if (idx_q == IDX_W'(DATA_W - 1)) begin
              idx_q <= '0;
`ifdef UART_TX_PARITY_EN
              if (par_en_q) begin
                tx_q    <= par_bit_q;
                state_q <= StParity;
              end else
`endif
              begin
                tx_q    <= 1'b1;
                state_q <= StStop;
              end
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (tick) begin
            tx_q    <= 1'b1;
            state_q <= StStop;
          end
        end
`endif
        StStop: begin
          if (tick) begin
            if (stop2_q && !stop_cnt_q) begin
              stop_cnt_q <= 1'b1;
            end else begin
              stop_cnt_q <= 1'b0;
              // Back-to-back frames go straight to StLoad with tx held high.
              state_q    <= (tx_enable && !fifo_empty) ? StLoad : StIdle;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule
